cpu_run_ctrl: RTL
=================

Name: cpu_run_ctrl

Overview:
Run-control sequencer for the onBoard CPU core. It conditions the raw start, stop and inc push-buttons and drives the core's clock-enable and core reset. It supports free-run, pause, single-step and halt modes. A cycle counter is exported for display on the 7-segment scanner.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive stable cycles before a button level is accepted (board build: 250000)
DB_W, 20, width of each debounce counter; must hold DEBOUNCE_CYCLES
PC_W, 8, width of the CPU program counter
CYC_W, 16, width of the executed-cycle counter

Ports:
clock  in  1  system clock; single clock domain
reset  in  1  synchronous, active-low reset
start  in  1  raw start button, asynchronous to clock
stop  in  1  raw stop button, asynchronous to clock
inc  in  1  raw single-step button, asynchronous to clock
halt_i  in  1  CPU has executed a HALT instruction
pc  in  PC_W  current CPU program counter
cpu_en  out  1  CPU clock-enable
cpu_rst_n  out  1  CPU core reset, active-low
run_state  out  3  current FSM state encoding
cycle_count  out  CYC_W  number of cycles with cpu_en=1 since last INIT

Behaviour:
- Reset is sampled at posedge clock with reset==0. On reset:
  - state=IDLE, cpu_en=0, cpu_rst_n=0, cycle_count=0.
  - All synchronizer, debounce and edge registers are cleared.
- Reset has priority over everything, including mid-RUN or mid-STEP.
- Button conditioning (per button):
  - 2-FF synchronizer.
  - Counter increments while the synced level differs from the filtered level, and clears otherwise.
  - When the counter reaches DEBOUNCE_CYCLES-1 and the levels still differ, the filtered level toggles on the next edge.
  - A 1-cycle press pulse (start_p/stop_p/inc_p) fires on each filtered rising edge.
  - Latency: a raw-high held from edge N gives a pulse high in the cycle after edge N+2+DEBOUNCE_CYCLES.
  - Glitches shorter than DEBOUNCE_CYCLES produce no pulse.
- FSM states and encoding: IDLE=0, INIT=1, RUN=2, PAUSE=3, STEP=4, HALT=5. Encodings 6 and 7 go to IDLE.
  - IDLE: cpu_rst_n=0, cpu_en=0. start_p -> INIT.
  - INIT: one cycle. cpu_rst_n=1, cpu_en=0, cycle_count cleared. Goes to RUN unconditionally.
  - RUN: cpu_en=1. halt_i -> HALT; stop_p -> PAUSE; inc_p and start_p are ignored.
  - PAUSE: cpu_en=0. stop_p -> IDLE (aborts and re-resets the CPU); start_p -> RUN; inc_p -> STEP.
  - STEP: cpu_en=1 for exactly one cycle. Next state is HALT if halt_i, otherwise PAUSE. Button pulses are ignored.
  - HALT: cpu_en=0. stop_p -> IDLE; start_p -> INIT (restart from reset).
- Simultaneous events priority: halt_i > stop_p > start_p > inc_p.
- halt_i is only honoured in cycles where cpu_en=1.
- Outputs are Moore-decoded from the state register:
  - cpu_en=1 iff state is RUN or STEP.
  - cpu_rst_n=0 iff state is IDLE.
- cycle_count increments on each edge where cpu_en=1 and saturates at all-ones. It holds in PAUSE/HALT and clears in INIT and on reset.
- run_state is the raw state register.

Optional Feature:
BREAKPOINT_EN
- With the macro defined:
  - Adds ports bp_valid (in, 1) and bp_addr (in, PC_W).
  - In RUN, if bp_valid and pc==bp_addr, next state is PAUSE; cpu_en drops on the following cycle.
  - halt_i and stop_p take priority over the breakpoint.
  - A bp_skip flag is set on leaving PAUSE via start_p and suppresses the match for the first RUN cycle only, so resume does not re-trap immediately.
  - STEP never traps.
- Without the macro: the ports are absent, no break logic is built, and pc is unused.

Decomposition:
- Package cpu_run_ctrl_pkg holds:
  - state typedef/localparams (IDLE..HALT, 3-bit),
  - default DEBOUNCE_CYCLES and CYC_W.
- Sub-module btn_conditioner (synchronizer + debounce + rising-edge pulse), parameterized by DEBOUNCE_CYCLES/DB_W, instantiated three times.
- The FSM, counter and breakpoint compare live in cpu_run_ctrl.

Test Plan:
1. Hold reset=0 for 3 cycles with buttons high -> cpu_en=0, cpu_rst_n=0, run_state=0, cycle_count=0. Release reset, press start for 10 cycles -> INIT for 1 cycle, then RUN with cpu_en=1, and cycle_count=20 after 20 RUN cycles.
2. Pulse start high for 2 cycles (DEBOUNCE_CYCLES=4) -> no start_p, state remains IDLE.
3. In RUN, press stop -> PAUSE, cycle_count frozen. Press inc three times -> exactly 3 single cycles with cpu_en=1, cycle_count +3, return to PAUSE each time.
4. In RUN, assert halt_i and stop_p in the same cycle -> HALT (not PAUSE). Then start -> INIT, cycle_count=0, RUN.
5. In PAUSE, press stop -> IDLE with cpu_rst_n=0. Assert reset=0 mid-STEP -> IDLE next edge, cpu_en=0.
6. (BREAKPOINT_EN) bp_valid=1, bp_addr=0x05, pc counting from 0 -> PAUSE after the pc==0x05 cycle. Start resumes, pc advances past 0x05 without re-trapping.

Source files
------------

// File: rtl/cpu_run_ctrl_pkg.sv
// Shared definitions for the CPU run-control sequencer: state encoding,
// default parameter values and small state-decode helpers.
package cpu_run_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_INIT  = 3'd1,
    ST_RUN   = 3'd2,
    ST_PAUSE = 3'd3,
    ST_STEP  = 3'd4,
    ST_HALT  = 3'd5
  } run_state_e;

  localparam int DEF_DEBOUNCE_CYCLES = 4;
  localparam int DEF_DB_W            = 20;
  localparam int DEF_PC_W            = 8;
  localparam int DEF_CYC_W           = 16;

  // The core is clocked only in the two executing states.
  function automatic logic state_runs_core(input run_state_e s);
    return (s == ST_RUN) || (s == ST_STEP);
  endfunction

  function automatic logic state_holds_reset(input run_state_e s);
    return (s == ST_IDLE);
  endfunction

endpackage

// File: rtl/btn_conditioner.sv
// Push-button conditioner: 2-FF synchronizer, counter debounce of the synced
// level, and a registered one-cycle pulse on each accepted rising edge.
module btn_conditioner
  import cpu_run_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int DB_W            = DEF_DB_W
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  output logic press_o
);

  logic            sync1_q;
  logic            sync2_q;
  logic            filt_q;
  logic            filt_d;
  logic            filt_prev_q;
  logic            press_q;
  logic [DB_W-1:0] cnt_q;
  logic [DB_W-1:0] cnt_d;

  // The counter only runs while the synced level disagrees with the accepted
  // level; any agreement restarts the qualification window.
  always_comb begin
    cnt_d  = '0;
    filt_d = filt_q;
    if (sync2_q != filt_q) begin
      if (cnt_q >= DB_W'(DEBOUNCE_CYCLES - 1)) begin
        filt_d = sync2_q;
        cnt_d  = '0;
      end else begin
        cnt_d = cnt_q + DB_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      filt_q      <= 1'b0;
      filt_prev_q <= 1'b0;
      press_q     <= 1'b0;
      cnt_q       <= '0;
    end else begin
      sync1_q     <= btn_i;
      sync2_q     <= sync1_q;
      filt_q      <= filt_d;
      filt_prev_q <= filt_q;
      press_q     <= filt_q & ~filt_prev_q;
      cnt_q       <= cnt_d;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run-control sequencer for the onBoard CPU: button conditioning, run FSM,
// Moore-decoded clock-enable/reset and a saturating executed-cycle counter.
// Optional macro BREAKPOINT_EN adds a pc breakpoint that traps RUN into PAUSE.
module cpu_run_ctrl
  import cpu_run_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int DB_W            = DEF_DB_W,
  parameter int PC_W            = DEF_PC_W,
  parameter int CYC_W           = DEF_CYC_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             inc,
  input  logic             halt_i,
  input  logic [PC_W-1:0]  pc,
`ifdef BREAKPOINT_EN
  input  logic             bp_valid,
  input  logic [PC_W-1:0]  bp_addr,
`endif
  output logic             cpu_en,
  output logic             cpu_rst_n,
  output logic [2:0]       run_state,
  output logic [CYC_W-1:0] cycle_count
);

  logic start_p;
  logic stop_p;
  logic inc_p;

  btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .DB_W(DB_W)) u_start_btn (
    .clk_i  (clock),
    .rst_ni (reset),
    .btn_i  (start),
    .press_o(start_p)
  );

  btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .DB_W(DB_W)) u_stop_btn (
    .clk_i  (clock),
    .rst_ni (reset),
    .btn_i  (stop),
    .press_o(stop_p)
  );

  btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .DB_W(DB_W)) u_inc_btn (
    .clk_i  (clock),
    .rst_ni (reset),
    .btn_i  (inc),
    .press_o(inc_p)
  );

  run_state_e       state_q;
  run_state_e       state_d;
  logic [CYC_W-1:0] cycle_q;
  logic [CYC_W-1:0] cycle_d;
  logic             bp_hit;

`ifdef BREAKPOINT_EN
  logic bp_skip_q;
  logic bp_skip_d;

  // A resume from PAUSE masks the match for one RUN cycle so the core can
  // execute the instruction it trapped on.
  assign bp_skip_d = (state_q == ST_PAUSE) && (state_d == ST_RUN);
  assign bp_hit    = bp_valid && (pc == bp_addr) && !bp_skip_q;

  always_ff @(posedge clock) begin
    if (!reset) begin
      bp_skip_q <= 1'b0;
    end else begin
      bp_skip_q <= bp_skip_d;
    end
  end
`else
  logic unused_pc;

  assign bp_hit    = 1'b0;
  assign unused_pc = ^pc;
`endif

  // Event priority within each state: halt_i > stop_p > start_p > inc_p.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start_p) state_d = ST_INIT;
      end
      ST_INIT: begin
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (halt_i)      state_d = ST_HALT;
        else if (stop_p) state_d = ST_PAUSE;
        else if (bp_hit) state_d = ST_PAUSE;
      end
      ST_PAUSE: begin
        if (stop_p)       state_d = ST_IDLE;
        else if (start_p) state_d = ST_RUN;
        else if (inc_p)   state_d = ST_STEP;
      end
      ST_STEP: begin
        state_d = halt_i ? ST_HALT : ST_PAUSE;
      end
      ST_HALT: begin
        if (stop_p)       state_d = ST_IDLE;
        else if (start_p) state_d = ST_INIT;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Clearing on entry to INIT makes the zero visible during the INIT cycle.
  always_comb begin
    cycle_d = cycle_q;
    if (state_d == ST_INIT) begin
      cycle_d = '0;
    end else if (cpu_en && (cycle_q != '1)) begin
      cycle_d = cycle_q + CYC_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cycle_q <= '0;
    end else begin
      state_q <= state_d;
      cycle_q <= cycle_d;
    end
  end

  assign cpu_en      = state_runs_core(state_q);
  assign cpu_rst_n   = !state_holds_reset(state_q);
  assign run_state   = state_q;
  assign cycle_count = cycle_q;

endmodule
